// File: rtl/board_vram_writer_if.sv
// rtl/board_vram_writer_if.sv - command handshake and VRAM write-port bundle for board_vram_writer
//
// Signals:
//   cmd_valid/cmd_ready  command handshake (transfer when both high)
//   cmd_op               0 = place piece, 1 = clear board
//   cmd_piece            5x5 bitmap, bit k = dy*5+dx, bit 0 top-left
//   cmd_x/cmd_y          piece origin column/row, 0..15
//   cmd_value            cell value written for each set bitmap bit
//   wr_en/wr_addr/wr_data VRAM write port (wren/wraddress/data)
//   busy                 high whenever the writer is not idle
//   done                 one-cycle pulse when an operation completes
// Modports: master = command source / VRAM side, slave = the writer.
interface board_vram_writer_if #(
    parameter int CELL_BITS = 6
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_op;
    logic [24:0]          cmd_piece;
    logic [3:0]           cmd_x;
    logic [3:0]           cmd_y;
    logic [CELL_BITS-1:0] cmd_value;
    logic                 wr_en;
    logic [7:0]           wr_addr;
    logic [CELL_BITS-1:0] wr_data;
    logic                 busy;
    logic                 done;

    modport master (
        output cmd_valid, cmd_op, cmd_piece, cmd_x, cmd_y, cmd_value,
        input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_piece, cmd_x, cmd_y, cmd_value,
        output cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/board_vram_writer.sv
// rtl/board_vram_writer.sv - turns place/clear commands into single-cell board VRAM writes
//
// Ports:
//   clk    system clock, shared with the VRAM
//   reset  asynchronous active-high reset; restarts the power-up board wipe
//   bus    board_vram_writer_if.slave: command handshake in, VRAM write port,
//          busy and done status out
// Every output is a register loaded from the current state, so a cell visited
// in one cycle appears on the write port in the next cycle and the VRAM
// captures it on the edge after that.
module board_vram_writer #(
    parameter int BOARD_W   = 14,
    parameter int CELL_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    board_vram_writer_if.slave   bus
);
    localparam logic [7:0] LAST_ADDR  = 8'(BOARD_W * BOARD_W - 1);
    localparam logic [7:0] ROW_STRIDE = 8'(BOARD_W);
    localparam logic [4:0] MAX_POS    = 5'(BOARD_W - 1);
    localparam logic [7:0] LAST_K     = 8'd24;

    typedef enum logic [1:0] {CLEAR, IDLE, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;       // clear address or piece bit index k
    logic [2:0]           dx_q, dx_d;
    logic [2:0]           dy_q, dy_d;
    logic [24:0]          piece_q, piece_d;   // shifted right so bit 0 is always cell k
    logic [3:0]           x_q, x_d;
    logic [3:0]           y_q, y_d;
    logic [CELL_BITS-1:0] value_q, value_d;

    logic                 wr_en_q, wr_en_d;
    logic [7:0]           wr_addr_q, wr_addr_d;
    logic [CELL_BITS-1:0] wr_data_q, wr_data_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Five bits wide so origins up to 15 plus offsets up to 4 never wrap
    // back onto the board before the range check.
    logic [4:0] col, row;
    assign col = {1'b0, x_q} + {2'b00, dx_q};
    assign row = {1'b0, y_q} + {2'b00, dy_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        piece_d   = piece_q;
        x_d       = x_q;
        y_d       = y_q;
        value_d   = value_q;
        wr_en_d   = 1'b0;
        wr_addr_d = 8'd0;
        wr_data_d = '0;
        ready_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                // ready_q gates the transfer so the first IDLE cycle after
                // DONE, where cmd_ready is still low, never accepts.
                if (bus.cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    piece_d = bus.cmd_piece;
                    x_d     = bus.cmd_x;
                    y_d     = bus.cmd_y;
                    value_d = bus.cmd_value;
                    cnt_d   = 8'd0;
                    dx_d    = 3'd0;
                    dy_d    = 3'd0;
                    state_d = bus.cmd_op ? CLEAR : SCAN;
                end
            end
            SCAN: begin
                wr_en_d   = piece_q[0] && (col <= MAX_POS) && (row <= MAX_POS);
                wr_addr_d = {3'b000, row} * ROW_STRIDE + {3'b000, col};
                wr_data_d = value_q;
                piece_d   = {1'b0, piece_q[24:1]};
                if (cnt_q == LAST_K) begin
                    state_d = DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (dx_q == 3'd4) begin
                        dx_d = 3'd0;
                        dy_d = dy_q + 3'd1;
                    end else begin
                        dx_d = dx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase

        busy_d = ~ready_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            cnt_q     <= 8'd0;
            dx_q      <= 3'd0;
            dy_q      <= 3'd0;
            piece_q   <= 25'd0;
            x_q       <= 4'd0;
            y_q       <= 4'd0;
            value_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            piece_q   <= piece_d;
            x_q       <= x_d;
            y_q       <= y_d;
            value_q   <= value_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_board_vram_writer.sv
// tb/tb_board_vram_writer.sv - self-checking bench for board_vram_writer
module tb_board_vram_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    board_vram_writer_if #(.CELL_BITS(6)) bus ();

    board_vram_writer #(.BOARD_W(14), .CELL_BITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic scramble_fields();
        bus.cmd_op    = 1'($urandom);
        bus.cmd_piece = 25'($urandom);
        bus.cmd_x     = 4'($urandom);
        bus.cmd_y     = 4'($urandom);
        bus.cmd_value = 6'($urandom);
    endtask

    // Caller sits at a negedge. Returns just after the transfer edge T, at the
    // negedge of cycle T, having checked that the handshake dropped.
    task automatic accept_cmd(input logic op, input logic [24:0] piece, input logic [3:0] x,
                              input logic [3:0] y, input logic [5:0] val, output bit ok);
        ok = 1'b0;
        bus.cmd_op    = op;
        bus.cmd_piece = piece;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_value = val;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%b after 400 cycles, required 1", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        scramble_fields();
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL accept_cycle: ready=%b busy=%b wr_en=%b, required ready=0 busy=1 wr_en=0",
                     bus.cmd_ready, bus.busy, bus.wr_en);
        end
    endtask

    // 196 zero writes, done pulse, then ready. First cycle checked is the one
    // after the caller's current negedge.
    task automatic check_clear_run(input string name);
        for (int a = 0; a < 196; a++) begin
            @(negedge clk);
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'(a) || bus.wr_data !== 6'd0 ||
                bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s_clear_%0d: wr_en=%b addr=%0d data=%0d ready=%b busy=%b done=%b, required 1/%0d/0/0/1/0",
                         name, a, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cmd_ready, bus.busy, bus.done, a);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.wr_en !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_clear_done: done=%b wr_en=%b ready=%b busy=%b, required 1/0/0/1",
                     name, bus.done, bus.wr_en, bus.cmd_ready, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear_idle: ready=%b done=%b busy=%b, required 1/0/0",
                     name, bus.cmd_ready, bus.done, bus.busy);
        end
    endtask

    // Place command checked cell by cell against the placement rule.
    // queue_clear raises a clear request mid-scan; reset_at >= 0 asserts reset
    // while that cell is on the write port and leaves reset released afterwards.
    task automatic run_place(input string name, input logic [24:0] piece, input logic [3:0] x,
                             input logic [3:0] y, input logic [5:0] val,
                             input bit queue_clear, input int reset_at);
        bit ok;
        int exp_cnt = 0;
        int act_cnt = 0;
        accept_cmd(1'b0, piece, x, y, val, ok);
        if (!ok) return;
        for (int k = 0; k < 25; k++) begin
            int  col, row, exp_addr;
            bit  exp_en;
            @(negedge clk);
            if (k == reset_at) begin
                reset = 1'b1;
                #1;
                checks++;
                if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_reset_async: wr_en=%b busy=%b ready=%b done=%b, required 0/1/0/0",
                             name, bus.wr_en, bus.busy, bus.cmd_ready, bus.done);
                end
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (bus.done !== 1'b0 || bus.wr_en !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_reset_hold: done=%b wr_en=%b, required 0/0", name, bus.done, bus.wr_en);
                    end
                end
                reset = 1'b0;
                return;
            end
            if (queue_clear && k == 5) begin
                scramble_fields();
                bus.cmd_op    = 1'b1;
                bus.cmd_valid = 1'b1;
            end
            col      = int'(x) + k % 5;
            row      = int'(y) + k / 5;
            exp_en   = piece[k] && col < 14 && row < 14;
            exp_addr = row * 14 + col;
            if (exp_en) exp_cnt++;
            if (bus.wr_en === 1'b1) act_cnt++;
            checks++;
            if (bus.wr_en !== exp_en || bus.cmd_ready !== 1'b0 || bus.done !== 1'b0 ||
                (exp_en && (bus.wr_addr !== 8'(exp_addr) || bus.wr_data !== val))) begin
                errors++;
                $display("FAIL %s_cell_%0d: wr_en=%b addr=%0d data=%0d ready=%b done=%b, required wr_en=%b addr=%0d data=%0d ready=0 done=0",
                         name, k, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cmd_ready, bus.done,
                         exp_en, exp_addr, val);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.wr_en !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b wr_en=%b ready=%b, required 1/0/0",
                     name, bus.done, bus.wr_en, bus.cmd_ready);
        end
        checks++;
        if (act_cnt != exp_cnt) begin
            errors++;
            $display("FAIL %s_write_count: got %0d writes, required %0d", name, act_cnt, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_again: ready=%b done=%b busy=%b, required 1/0/0",
                     name, bus.cmd_ready, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 8'd0 || bus.wr_data !== 6'd0 ||
            bus.cmd_ready !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: wr_en=%b addr=%0d data=%0d ready=%b done=%b busy=%b, required 0/0/0/0/0/1",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.cmd_ready, bus.done, bus.busy);
        end
    endtask

    task automatic test_powerup_clear();
        reset = 1'b0;
        check_clear_run("powerup");
    endtask

    task automatic test_full_origin();
        run_place("full_origin", 25'h1FFFFFF, 4'd0, 4'd0, 6'h15, 1'b0, -1);
    endtask

    task automatic test_sparse_edge();
        run_place("sparse_edge", 25'h0000023, 4'd13, 4'd12, 6'd3, 1'b0, -1);
    endtask

    task automatic test_off_board();
        run_place("off_board", 25'h1FFFFFF, 4'd15, 4'd15, 6'h2A, 1'b0, -1);
    endtask

    task automatic test_clear_cmd();
        bit ok;
        accept_cmd(1'b1, 25'($urandom), 4'($urandom), 4'($urandom), 6'h3F, ok);
        if (ok) check_clear_run("clear_cmd");
    endtask

    task automatic test_random_places();
        for (int i = 0; i < 8; i++) begin
            run_place($sformatf("random%0d", i), 25'($urandom), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 6'($urandom), 1'b0, -1);
        end
    endtask

    task automatic test_handshake();
        run_place("handshake", 25'($urandom), 4'($urandom_range(8, 15)), 4'($urandom_range(0, 9)),
                  6'($urandom), 1'b1, -1);
        // run_place ends at the first ready cycle with the clear still pending
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL handshake_accept: ready=%b busy=%b wr_en=%b, required 0/1/0",
                     bus.cmd_ready, bus.busy, bus.wr_en);
        end
        check_clear_run("handshake");
    endtask

    task automatic test_reset_mid_scan();
        run_place("reset_mid_scan", 25'h1FFFFFF, 4'd2, 4'd3, 6'h11, 1'b0, 10);
        check_clear_run("after_reset");
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_piece = 25'd0;
        bus.cmd_x     = 4'd0;
        bus.cmd_y     = 4'd0;
        bus.cmd_value = 6'd0;
        test_reset();
        test_powerup_clear();
        test_full_origin();
        test_sparse_edge();
        test_off_board();
        test_clear_cmd();
        test_random_places();
        test_handshake();
        test_reset_mid_scan();
        test_full_origin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/board_vram_writer.md
# board_vram_writer

Write-side controller for the 14x14x6-bit board VRAM whose read port feeds the VGA scan-out. It accepts piece-placement and board-clear commands over a valid/ready handshake. It converts each command into single-cell writes on the VRAM write port (`wraddress`/`data`/`wren`), one cell per clock. It also wipes the board automatically after reset, so the display never shows stale contents.

## Interface
Parameters:
- `BOARD_W`, 14, board width and height in cells; fixes address = row*BOARD_W + col, 196 cells.
- `CELL_BITS`, 6, width of one cell value.

Ports:
- `clk`  in  1  system clock; same clock as the VRAM.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  1  0 = place piece, 1 = clear board.
- `cmd_piece`  in  25  5x5 piece bitmap; bit k = dy*5+dx, with bit 0 at top-left.
- `cmd_x`  in  4  piece origin column, 0..15.
- `cmd_y`  in  4  piece origin row, 0..15.
- `cmd_value`  in  6  cell value written for each set bit (player colour code).
- `wr_en`  out  1  VRAM `wren`.
- `wr_addr`  out  8  VRAM `wraddress`.
- `wr_data`  out  6  VRAM `data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when an operation completes.

## Operation
- States: CLEAR, IDLE, SCAN, DONE.
- Reset values: state = CLEAR, cell counter = 0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cmd_ready`=0, `done`=0, `busy`=1.
- CLEAR:
  - Drives `wr_en`=1, `wr_data`=0, `wr_addr`=counter, for counter 0..195.
  - After address 195 is written, goes to DONE.
  - Entered from reset or from a clear command.
- IDLE:
  - `cmd_ready`=1; all other outputs are 0.
  - A transfer occurs when `cmd_valid` & `cmd_ready`.
  - Command fields are latched at the transfer edge; inputs are don't-care afterwards.
  - Next state: op=1 goes to CLEAR (counter=0); op=0 goes to SCAN (k=0).
- SCAN:
  - Visits k = 0..24; dx = k mod 5, dy = k div 5.
  - col = x+dx and row = y+dy, both 5-bit; no truncation before the range check.
  - `wr_en`=1 only if `piece[k]`=1, col<=13 and row<=13.
  - `wr_addr` = row*14+col, in range 0..195; `wr_data` = `cmd_value`.
  - If `wr_en`=0, `wr_addr`/`wr_data` are don't-care and the VRAM must not be written.
  - After k=24, goes to DONE.
  - Off-board cells are skipped silently: no wrap to the next row, no error.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- No overlap or collision checking; later writes overwrite earlier ones.
- `cmd_ready` is low in CLEAR, SCAN and DONE. The upstream side holds `cmd_valid` and its fields until accepted.

## Timing
- All outputs are registered.
- The write for a visited cell is presented in the cycle that cell is visited; the VRAM captures it on the following edge.
- Place command accepted at edge T:
  - SCAN occupies cycles T+1..T+25 (cell k in cycle T+1+k).
  - `done` is high in cycle T+26.
  - `cmd_ready` is high again from cycle T+27.
- Clear command accepted at T:
  - Writes addr 0..195 in cycles T+1..T+196.
  - `done` in T+197; `cmd_ready` from T+198.
- Power-up: first write (addr 0) in the first cycle after reset deasserts. `done` pulses after addr 195; IDLE follows.
- Reset asserted mid-CLEAR or mid-SCAN:
  - Outputs go to reset values immediately (asynchronously).
  - The pending command is discarded with no `done` pulse.
  - The full clear restarts from addr 0 after release.
- `cmd_valid` during DONE is not accepted; acceptance happens at the first IDLE cycle.
- Back-to-back commands therefore have a one-cycle IDLE gap minimum.

## Test plan
- Power-up clear: release reset. Require `wr_en`=1 with `wr_addr` 0..195 consecutive and `wr_data`=0 for 196 cycles. Then `done` pulse, then `cmd_ready`=1.
- Full 5x5 at origin: piece=25'h1FFFFFF, x=0, y=0, value=6'h15.
  - Require 25 writes to addresses 0-4, 14-18, 28-32, 42-46, 56-60, all with data 6'h15.
  - `done` at T+26.
- Sparse piece at edge: piece=bits {0,1,5}, x=13, y=12, value=3.
  - Require writes to addr 181 (k=0) and 195 (k=5) only.
  - k=1 (col 14) is skipped; exactly 2 `wr_en` cycles.
- Fully off-board: x=15, y=15, piece all ones. Require zero `wr_en` cycles, `done` still at T+26.
- Handshake: hold `cmd_valid` high with a queued clear command during a SCAN. Require acceptance only in the first IDLE cycle, then 196 zero writes.
- Reset mid-SCAN: assert `reset` at k=10. Require `wr_en`=0 immediately and no `done`. After release, a full clear starting from addr 0.
